// File: rtl/row_cache_array_pkg.sv
// +----------------------------------------------------------------------+
// | row_cache_array_pkg : BankFSM access codes and bank state encoding    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package row_cache_array_pkg;

   localparam logic [4:0] BFSM_RD0 = 5'b01011;
   localparam logic [4:0] BFSM_RD1 = 5'b01100;
   localparam logic [4:0] BFSM_WR0 = 5'b10010;
   localparam logic [4:0] BFSM_WR1 = 5'b10011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVICT = 2'd1,
      ST_FILL  = 2'd2
   } bank_state_e;

   function automatic logic is_rd(input logic [4:0] code);
      return (code == BFSM_RD0) || (code == BFSM_RD1);
   endfunction

   function automatic logic is_wr(input logic [4:0] code);
      return (code == BFSM_WR0) || (code == BFSM_WR1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/row_cache_bank.sv
// +----------------------------------------------------------------------+
// | row_cache_bank : fully associative LRU row cache for one DRAM bank    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module row_cache_bank
   import row_cache_array_pkg::*;
#(
   parameter int CHWIDTH   = 5,
   parameter int ADDRWIDTH = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDRWIDTH-1:0] row_id,
   input  logic [4:0]           bank_fsm,
   input  logic                 sync,
   output logic [CHWIDTH-1:0]   c_row_id,
   output logic                 evict_req,
   output logic                 fill_req,
   output logic [ADDRWIDTH-1:0] xfer_row,
   output logic                 busy,
   output logic                 hit_evt,
   output logic                 miss_evt
);

   localparam int WAYS = 2 ** CHWIDTH;

   logic [ADDRWIDTH-1:0] tag [WAYS];
   logic [CHWIDTH-1:0]   age [WAYS];
   logic [WAYS-1:0]      valid;
   logic [WAYS-1:0]      dirty;
   bank_state_e          state;
   logic [CHWIDTH-1:0]   victim;
   logic [ADDRWIDTH-1:0] miss_row;
   logic                 miss_wr;

   logic                 access;
   logic                 wr;
   logic                 hit_found;
   logic [CHWIDTH-1:0]   hit_way;
   logic                 inv_found;
   logic [CHWIDTH-1:0]   inv_way;
   logic [CHWIDTH-1:0]   lru_way;
   logic [CHWIDTH-1:0]   new_victim;
   logic                 touch_en;
   logic [CHWIDTH-1:0]   touch_way;

   always_comb begin
      hit_found = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      lru_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid[w] && (tag[w] == row_id)) begin
            hit_found = 1'b1;
            hit_way   = CHWIDTH'(w);
         end
         if (!valid[w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = CHWIDTH'(w);
         end
         if (age[w] == CHWIDTH'(WAYS - 1))
            lru_way = CHWIDTH'(w);
      end
   end

   assign wr         = is_wr(bank_fsm);
   assign access     = (state == ST_IDLE) && (is_rd(bank_fsm) || wr);
   assign hit_evt    = access && hit_found;
   assign miss_evt   = access && !hit_found;
   assign new_victim = inv_found ? inv_way : lru_way;
   assign touch_en   = hit_evt || ((state == ST_FILL) && sync);
   assign touch_way  = hit_evt ? hit_way : victim;

   // Ages stay a permutation: only ways younger than the touched one shift.
   always_ff @(posedge clk) begin
      for (int w = 0; w < WAYS; w++) begin
         if (rst)
            age[w] <= CHWIDTH'(w);
         else if (touch_en) begin
            if (CHWIDTH'(w) == touch_way)
               age[w] <= '0;
            else if (age[w] < age[touch_way])
               age[w] <= age[w] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < WAYS; w++)
            tag[w] <= '0;
         valid    <= '0;
         dirty    <= '0;
         state    <= ST_IDLE;
         c_row_id <= '0;
         victim   <= '0;
         miss_row <= '0;
         miss_wr  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hit_evt) begin
                  c_row_id <= hit_way;
                  if (wr)
                     dirty[hit_way] <= 1'b1;
               end else if (miss_evt) begin
                  victim   <= new_victim;
                  miss_row <= row_id;
                  miss_wr  <= wr;
                  state    <= (valid[new_victim] && dirty[new_victim]) ? ST_EVICT : ST_FILL;
               end
            end
            ST_EVICT: begin
               if (sync)
                  state <= ST_FILL;
            end
            ST_FILL: begin
               if (sync) begin
                  tag[victim]   <= miss_row;
                  valid[victim] <= 1'b1;
                  dirty[victim] <= miss_wr;
                  c_row_id      <= victim;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign evict_req = (state == ST_EVICT);
   assign fill_req  = (state == ST_FILL);
   assign busy      = (state != ST_IDLE);
   assign xfer_row  = (state == ST_EVICT) ? tag[victim] :
                      (state == ST_FILL)  ? miss_row    : '0;

endmodule

`default_nettype wire

// File: rtl/row_cache_array.sv
// +----------------------------------------------------------------------+
// | row_cache_array : per-bank row caches with shared hold and statistics |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module row_cache_array
   import row_cache_array_pkg::*;
#(
   parameter int BGWIDTH   = 2,
   parameter int BAWIDTH   = 2,
   parameter int CHWIDTH   = 5,
   parameter int ADDRWIDTH = 17,
   parameter int STATWIDTH = 32
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic [(2**BGWIDTH)*(2**BAWIDTH)*ADDRWIDTH-1:0]        RowId,
   input  logic [(2**BGWIDTH)*(2**BAWIDTH)*5-1:0]                BankFSM,
   input  logic [(2**BGWIDTH)*(2**BAWIDTH)-1:0]                  sync,
   output logic [(2**BGWIDTH)*(2**BAWIDTH)*CHWIDTH-1:0]          cRowId,
   output logic [(2**BGWIDTH)*(2**BAWIDTH)-1:0]                  evict_req,
   output logic [(2**BGWIDTH)*(2**BAWIDTH)-1:0]                  fill_req,
   output logic [(2**BGWIDTH)*(2**BAWIDTH)*ADDRWIDTH-1:0]        xfer_row,
   output logic                                                  hold,
   output logic [STATWIDTH-1:0]                                  hit_cnt,
   output logic [STATWIDTH-1:0]                                  miss_cnt
);

   localparam int BANKGROUPS    = 2 ** BGWIDTH;
   localparam int BANKSPERGROUP = 2 ** BAWIDTH;
   localparam int BANKS         = BANKGROUPS * BANKSPERGROUP;
   localparam int SUMW          = STATWIDTH + BGWIDTH + BAWIDTH + 1;

   logic [BANKS-1:0] busy;
   logic [BANKS-1:0] hit_evt;
   logic [BANKS-1:0] miss_evt;
   logic [SUMW-1:0]  hit_sum;
   logic [SUMW-1:0]  miss_sum;

   for (genvar bg = 0; bg < BANKGROUPS; bg++) begin : g_bg
      for (genvar ba = 0; ba < BANKSPERGROUP; ba++) begin : g_ba
         localparam int B = bg * BANKSPERGROUP + ba;
         row_cache_bank #(
            .CHWIDTH   (CHWIDTH),
            .ADDRWIDTH (ADDRWIDTH)
         ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .row_id    (RowId[B*ADDRWIDTH +: ADDRWIDTH]),
            .bank_fsm  (BankFSM[B*5 +: 5]),
            .sync      (sync[B]),
            .c_row_id  (cRowId[B*CHWIDTH +: CHWIDTH]),
            .evict_req (evict_req[B]),
            .fill_req  (fill_req[B]),
            .xfer_row  (xfer_row[B*ADDRWIDTH +: ADDRWIDTH]),
            .busy      (busy[B]),
            .hit_evt   (hit_evt[B]),
            .miss_evt  (miss_evt[B])
         );
      end
   end

   assign hold = |busy;

   // The sum is wide enough to hold a full counter plus one event per bank.
   always_comb begin
      hit_sum  = SUMW'(hit_cnt);
      miss_sum = SUMW'(miss_cnt);
      for (int b = 0; b < BANKS; b++) begin
         hit_sum  = hit_sum  + SUMW'(hit_evt[b]);
         miss_sum = miss_sum + SUMW'(miss_evt[b]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         hit_cnt  <= (hit_sum  > SUMW'({STATWIDTH{1'b1}})) ? {STATWIDTH{1'b1}} : hit_sum[STATWIDTH-1:0];
         miss_cnt <= (miss_sum > SUMW'({STATWIDTH{1'b1}})) ? {STATWIDTH{1'b1}} : miss_sum[STATWIDTH-1:0];
      end
   end

endmodule

`default_nettype wire

// File: doc/row_cache_array.md
ROW_CACHE_ARRAY -- requirements
Module: row_cache_array

Interface
REQ-001 SHALL have parameter BGWIDTH, default 2, bank-group address bits (BANKGROUPS = 2**BGWIDTH).
REQ-002 SHALL have parameter BAWIDTH, default 2, bank address bits (BANKSPERGROUP = 2**BAWIDTH).
REQ-003 SHALL have parameter CHWIDTH, default 5, cache way-index bits (WAYS = 2**CHWIDTH, fully associative per bank).
REQ-004 SHALL have parameter ADDRWIDTH, default 17, DRAM row address bits.
REQ-005 SHALL have parameter STATWIDTH, default 32, hit/miss counter width.
REQ-006 SHALL have port clk, input, 1 bit, sole clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port RowId, input, [ADDRWIDTH] per [BG][BA], row addressed by each bank.
REQ-009 SHALL have port BankFSM, input, [5] per [BG][BA], bank state code; 5'b01011/5'b01100 = read access, 5'b10010/5'b10011 = write access.
REQ-010 SHALL have port sync, input, 1 per [BG][BA], one-cycle pulse marking completion of the pending evict or fill transfer.
REQ-011 SHALL have port cRowId, output, [CHWIDTH] per [BG][BA], cache way holding the current row.
REQ-012 SHALL have port evict_req, output, 1 per [BG][BA], dirty victim writeback requested.
REQ-013 SHALL have port fill_req, output, 1 per [BG][BA], row fill requested.
REQ-014 SHALL have port xfer_row, output, [ADDRWIDTH] per [BG][BA], row of the active evict or fill.
REQ-015 SHALL have port hold, output, 1 bit, OR of all bank busy flags.
REQ-016 SHALL have ports hit_cnt and miss_cnt, output, [STATWIDTH] each, totals across all banks.

Function
REQ-017 Each bank SHALL keep per way: tag[ADDRWIDTH], valid, dirty, age[CHWIDTH].
REQ-018 Bank FSM states SHALL be IDLE, EVICT, FILL; only IDLE accepts accesses.
REQ-019 In IDLE, an access (RD or WR decode) in cycle t SHALL be looked up combinationally against all valid tags; the result is registered at t+1.
REQ-020 On hit at way w: cRowId = w at t+1; dirty[w] set if WR; LRU touch of w; hit_cnt +1; state stays IDLE.
REQ-021 On miss: victim = lowest-index invalid way, else the way with age == WAYS-1; miss_cnt +1; next state EVICT if victim valid and dirty, else FILL.
REQ-022 EVICT: evict_req = 1, xfer_row = victim tag; on sync, go to FILL.
REQ-023 FILL: fill_req = 1, xfer_row = missed row; on sync, install tag, set valid, set dirty = (miss was WR), LRU touch, cRowId = victim; go to IDLE.
REQ-024 LRU touch of w: every way with age < age[w] increments, age[w] = 0; ages SHALL always form a permutation of 0..WAYS-1.
REQ-025 Bank busy SHALL be 1 in EVICT and FILL, so hold rises at t+1 after a miss and falls the cycle after the fill sync.
REQ-026 Accesses outside IDLE SHALL be ignored (no lookup, no count); sync in IDLE SHALL be ignored.
REQ-027 Missed row and WR flag SHALL be latched at the miss; RowId changes while busy have no effect.
REQ-028 Counters SHALL saturate at all-ones; simultaneous events from several banks in one cycle SHALL add by their count.
REQ-029 Banks SHALL operate independently; one bank busy never stalls another bank's internal FSM.

Reset
REQ-030 rst SHALL clear valid, dirty, tags, cRowId, counters, evict_req, fill_req, xfer_row and hold to 0; age[i] = i; state = IDLE.
REQ-031 rst asserted mid-EVICT/FILL SHALL abandon the transfer with no tag install; outputs are at reset values the following cycle.

Structure
REQ-032 A shared package SHALL hold the BankFSM read/write code constants and the bank state enum.
REQ-033 A sub-module row_cache_bank SHALL implement one bank (tags, LRU, FSM); the top generates BANKGROUPS x BANKSPERGROUP instances plus the hold OR tree and counter adders.

Verification
REQ-034 After reset, read row 0x100 on bank [0][0] -> miss_cnt=1, fill_req=1, hold=1; sync -> cRowId=0, hold=0 next cycle.
REQ-035 Re-read row 0x100 on [0][0] -> hit_cnt=1, cRowId=0, no fill_req, hold stays 0.
REQ-036 CHWIDTH=2: fill rows 1,2,3,4, then read row 5 -> victim way 0 (row 1, LRU), fill_req with xfer_row=5.
REQ-037 Write row 1 (dirty), then force eviction of row 1 -> evict_req=1 with xfer_row=1; sync -> fill_req; sync -> IDLE.
REQ-038 Misses on [1][2] and [3][3] in the same cycle -> miss_cnt +2; hold held until both banks complete fill.
REQ-039 rst pulsed during FILL -> next cycle fill_req=0, hold=0, subsequent read of the same row misses.
